// File: rtl/mem_arbiter_pkg.sv
// Shared types for the byte-serial memory arbiter: size codes, FSM states,
// request owner and the size-to-byte-count decode.
package mem_arbiter_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    StIdle,
    StXfer,
    StDone
  } state_e;

  typedef enum logic {
    OWN_IF,
    OWN_DM
  } owner_e;

  // Size code 11 is treated as a word access.
  function automatic logic [2:0] size_to_count(input logic [1:0] size);
    logic [2:0] n;
    unique case (size)
      SZ_BYTE: n = 3'd1;
      SZ_HALF: n = 3'd2;
      default: n = 3'd4;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch port, data port and byte-wide memory bus around the arbiter.
interface mem_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 32
) ();

  logic                  if_req;
  logic [ADDR_WIDTH-1:0] if_addr;
  logic                  if_done;
  logic [31:0]           if_data;

  logic                  dm_req;
  logic                  dm_rw;
  logic [1:0]            dm_size;
  logic [ADDR_WIDTH-1:0] dm_addr;
  logic [31:0]           dm_wdata;
  logic                  dm_done;
  logic [31:0]           dm_rdata;

  logic                  mem_rw;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [7:0]            mem_write;
  logic [7:0]            mem_read;

  logic                  busy;

  // Arbiter side.
  modport slave (
    input  if_req, if_addr, dm_req, dm_rw, dm_size, dm_addr, dm_wdata, mem_read,
    output if_done, if_data, dm_done, dm_rdata, mem_rw, mem_addr, mem_write, busy
  );

  // Requesters and memory side.
  modport master (
    output if_req, if_addr, dm_req, dm_rw, dm_size, dm_addr, dm_wdata, mem_read,
    input  if_done, if_data, dm_done, dm_rdata, mem_rw, mem_addr, mem_write, busy
  );

endinterface

// File: rtl/mem_byte_assembler.sv
// Collects read bytes into a little-endian word; cleared on each accept so
// bytes beyond the access size read as zero.
module mem_byte_assembler (
  input  logic        clock,
  input  logic        reset,
  input  logic        clear,
  input  logic        capture,
  input  logic [1:0]  cnt,
  input  logic [7:0]  mem_read,
  output logic [31:0] result
);

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      result <= '0;
    end else if (capture) begin
      result[8*cnt +: 8] <= mem_read;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates fetch and data requests onto a byte-wide single-port memory,
// one byte per cycle, data port first on a tie.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32
) (
  input logic          clock,
  input logic          reset,
  mem_arbiter_if.slave bus
);

  state_e                state_q, state_d;
  logic [1:0]            cnt_q, cnt_d;
  logic [1:0]            last_q;
  logic                  rw_q;
  owner_e                owner_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           wdata_q;
  logic [31:0]           if_data_q, dm_data_q;
  logic [31:0]           result;
  logic                  accept_dm, accept_if;
  logic [2:0]            dm_count;
  logic                  in_xfer, in_done;

  assign dm_count = size_to_count(bus.dm_size);
  assign in_xfer  = (state_q == StXfer);
  assign in_done  = (state_q == StDone);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    accept_dm = 1'b0;
    accept_if = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.dm_req) begin
          accept_dm = 1'b1;
          state_d   = StXfer;
          cnt_d     = 2'd0;
        end else if (bus.if_req) begin
          accept_if = 1'b1;
          state_d   = StXfer;
          cnt_d     = 2'd0;
        end
      end
      StXfer: begin
        if (cnt_q == last_q) state_d = StDone;
        else                 cnt_d   = cnt_q + 2'd1;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      last_q    <= '0;
      rw_q      <= 1'b0;
      owner_q   <= OWN_IF;
      addr_q    <= '0;
      wdata_q   <= '0;
      if_data_q <= '0;
      dm_data_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept_dm) begin
        owner_q <= OWN_DM;
        addr_q  <= bus.dm_addr;
        rw_q    <= bus.dm_rw;
        wdata_q <= bus.dm_wdata;
        last_q  <= 2'(dm_count - 3'd1);
      end else if (accept_if) begin
        owner_q <= OWN_IF;
        addr_q  <= bus.if_addr;
        rw_q    <= 1'b0;
        wdata_q <= '0;
        last_q  <= 2'd3;
      end
      if (in_done) begin
        if (owner_q == OWN_IF) if_data_q <= result;
        else                   dm_data_q <= result;
      end
    end
  end

  mem_byte_assembler u_assembler (
    .clock    (clock),
    .reset    (reset),
    .clear    (accept_dm | accept_if),
    .capture  (in_xfer & ~rw_q),
    .cnt      (cnt_q),
    .mem_read (bus.mem_read),
    .result   (result)
  );

  // Write enable is masked by reset so an aborting edge cannot land a byte.
  assign bus.mem_rw    = in_xfer & rw_q & ~reset;
  assign bus.mem_addr  = in_xfer ? addr_q + ADDR_WIDTH'(cnt_q) : '0;
  assign bus.mem_write = in_xfer ? wdata_q[8*cnt_q +: 8] : 8'h00;
  assign bus.if_done   = in_done & (owner_q == OWN_IF);
  assign bus.dm_done   = in_done & (owner_q == OWN_DM);
  assign bus.if_data   = bus.if_done ? result : if_data_q;
  assign bus.dm_rdata  = bus.dm_done ? result : dm_data_q;
  assign bus.busy      = in_xfer | in_done;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small byte memory model on the bus.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic clock = 1'b0;
  logic reset;

  mem_arbiter_if #(.ADDR_WIDTH(32)) bus ();

  mem_arbiter #(.ADDR_WIDTH(32)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  logic [7:0] mem [512];
  logic       pre_we;
  logic [8:0] pre_addr;
  logic [7:0] pre_data;

  assign bus.mem_read = mem[bus.mem_addr[8:0]];

  always @(posedge clock) begin
    if (bus.mem_rw)  mem[bus.mem_addr[8:0]] <= bus.mem_write;
    else if (pre_we) mem[pre_addr] <= pre_data;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic preload(input logic [8:0] a, input logic [7:0] d);
    pre_we   = 1'b1;
    pre_addr = a;
    pre_data = d;
    tick();
    pre_we   = 1'b0;
  endtask

  // Called in the first XFER cycle; walks n byte cycles and ends in DONE.
  task automatic xfer_check(input string tag, input logic [31:0] base, input int n,
                            input logic rw, input logic [31:0] wdata, input logic is_dm);
    for (int i = 0; i < n; i++) begin
      check({tag, "_addr"}, bus.mem_addr, base + 32'(i));
      check({tag, "_rw"}, {31'b0, bus.mem_rw}, {31'b0, rw});
      if (rw) check({tag, "_wbyte"}, {24'b0, bus.mem_write}, {24'b0, wdata[8*i +: 8]});
      tick();
    end
    check({tag, "_done"}, {30'b0, bus.dm_done, bus.if_done}, is_dm ? 32'd2 : 32'd1);
    check({tag, "_busy_done"}, {31'b0, bus.busy}, 32'd1);
  endtask

  initial begin
    reset        = 1'b1;
    pre_we       = 1'b0;
    pre_addr     = '0;
    pre_data     = '0;
    bus.if_req   = 1'b0;
    bus.if_addr  = '0;
    bus.dm_req   = 1'b0;
    bus.dm_rw    = 1'b0;
    bus.dm_size  = SZ_BYTE;
    bus.dm_addr  = '0;
    bus.dm_wdata = '0;
    tick();
    tick();
    reset = 1'b0;
    check("rst_busy", {31'b0, bus.busy}, 32'd0);
    check("rst_done", {30'b0, bus.dm_done, bus.if_done}, 32'd0);
    check("rst_if_data", bus.if_data, 32'd0);
    check("rst_dm_rdata", bus.dm_rdata, 32'd0);
    check("rst_mem_bus", {bus.mem_addr[22:0], bus.mem_write, bus.mem_rw}, 32'd0);

    preload(9'd0, 8'h83); preload(9'd1, 8'h20); preload(9'd2, 8'h40); preload(9'd3, 8'h06);
    preload(9'd100, 8'h11); preload(9'd101, 8'h22);
    preload(9'd200, 8'hE0); preload(9'd201, 8'hE1);
    preload(9'd202, 8'hE2); preload(9'd203, 8'hE3);
    preload(9'd511, 8'h5A);

    // 1: fetch word at 0
    bus.if_req = 1'b1; bus.if_addr = 32'd0;
    tick();
    xfer_check("t1", 32'd0, 4, 1'b0, 32'd0, 1'b0);
    check("t1_if_data", bus.if_data, 32'h0640_2083);
    bus.if_req = 1'b0;
    tick();
    check("t1_idle_done", {31'b0, bus.if_done}, 32'd0);
    check("t1_if_hold", bus.if_data, 32'h0640_2083);

    // 2: byte write at 100
    bus.dm_req = 1'b1; bus.dm_rw = 1'b1; bus.dm_size = SZ_BYTE;
    bus.dm_addr = 32'd100; bus.dm_wdata = 32'h1234_56AB;
    tick();
    xfer_check("t2", 32'd100, 1, 1'b1, 32'h1234_56AB, 1'b1);
    check("t2_rdata_zero", bus.dm_rdata, 32'd0);
    check("t2_rw_done", {31'b0, bus.mem_rw}, 32'd0);
    bus.dm_req = 1'b0; bus.dm_rw = 1'b0;
    tick();
    check("t2_mem100", {24'b0, mem[100]}, 32'hAB);
    check("t2_mem101", {24'b0, mem[101]}, 32'h22);

    // 3: simultaneous data read and fetch; data wins
    preload(9'd100, 8'h66); preload(9'd101, 8'hDB); preload(9'd102, 8'hFF); preload(9'd103, 8'h55);
    bus.dm_req = 1'b1; bus.dm_rw = 1'b0; bus.dm_size = SZ_WORD; bus.dm_addr = 32'd100;
    bus.if_req = 1'b1; bus.if_addr = 32'd0;
    tick();
    xfer_check("t3dm", 32'd100, 4, 1'b0, 32'd0, 1'b1);
    check("t3_dm_rdata", bus.dm_rdata, 32'h55FF_DB66);
    bus.dm_req = 1'b0;
    tick();
    check("t3_idle_busy", {31'b0, bus.busy}, 32'd0);
    tick();
    xfer_check("t3if", 32'd0, 4, 1'b0, 32'd0, 1'b0);
    check("t3_if_data", bus.if_data, 32'h0640_2083);
    check("t3_dm_hold", bus.dm_rdata, 32'h55FF_DB66);
    bus.if_req = 1'b0;
    tick();

    // 4: half read wrapping the address space
    bus.dm_req = 1'b1; bus.dm_rw = 1'b0; bus.dm_size = SZ_HALF; bus.dm_addr = 32'hFFFF_FFFF;
    tick();
    xfer_check("t4", 32'hFFFF_FFFF, 2, 1'b0, 32'd0, 1'b1);
    check("t4_dm_rdata", bus.dm_rdata, 32'h0000_835A);
    bus.dm_req = 1'b0;
    tick();

    // 5: word write aborted by reset during the third byte
    bus.dm_req = 1'b1; bus.dm_rw = 1'b1; bus.dm_size = SZ_WORD;
    bus.dm_addr = 32'd200; bus.dm_wdata = 32'hDDCC_BBAA;
    tick();
    check("t5_addr0", bus.mem_addr, 32'd200);
    tick();
    check("t5_addr1", bus.mem_addr, 32'd201);
    tick();
    check("t5_addr2", bus.mem_addr, 32'd202);
    reset = 1'b1; bus.dm_req = 1'b0; bus.dm_rw = 1'b0;
    tick();
    reset = 1'b0;
    check("t5_busy", {31'b0, bus.busy}, 32'd0);
    check("t5_done", {30'b0, bus.dm_done, bus.if_done}, 32'd0);
    check("t5_mem_bus", {bus.mem_addr[22:0], bus.mem_write, bus.mem_rw}, 32'd0);
    check("t5_data", bus.dm_rdata | bus.if_data, 32'd0);
    check("t5_mem", {mem[203], mem[202], mem[201], mem[200]}, 32'hE3E2_BBAA);
    tick();
    check("t5_no_done", {30'b0, bus.dm_done, bus.if_done}, 32'd0);
    bus.if_req = 1'b1; bus.if_addr = 32'd0;
    tick();
    xfer_check("t5if", 32'd0, 4, 1'b0, 32'd0, 1'b0);
    check("t5_if_data", bus.if_data, 32'h0640_2083);
    bus.if_req = 1'b0;
    tick();

    // 6: request held through done is served again after one idle cycle
    bus.dm_req = 1'b1; bus.dm_rw = 1'b0; bus.dm_size = SZ_BYTE; bus.dm_addr = 32'd101;
    tick();
    xfer_check("t6a", 32'd101, 1, 1'b0, 32'd0, 1'b1);
    check("t6a_rdata", bus.dm_rdata, 32'h0000_00DB);
    tick();
    check("t6_idle_busy", {31'b0, bus.busy}, 32'd0);
    check("t6_idle_done", {31'b0, bus.dm_done}, 32'd0);
    tick();
    xfer_check("t6b", 32'd101, 1, 1'b0, 32'd0, 1'b1);
    check("t6b_rdata", bus.dm_rdata, 32'h0000_00DB);
    bus.dm_req = 1'b0;
    tick();
    check("t6_end_busy", {31'b0, bus.busy}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sequences the byte-wide, single-port memory for the CPU.
- Arbitrates between an instruction-fetch port (32-bit reads only) and a data port (1/2/4-byte reads and writes).
- Splits each access into consecutive byte cycles on the memory bus. On reads, assembles the bytes into a little-endian word.
- Sits between the IF/MEM pipeline stages and the memory model.

Parameters:
ADDR_WIDTH, 32, width of all address ports and of the internal address adder.

Ports:
clock  in  1  system clock, all state changes on posedge
reset  in  1  synchronous, active-high reset
if_req  in  1  fetch request; level, held until if_done
if_addr  in  ADDR_WIDTH  fetch byte address; stable while if_req
if_done  out  1  one-cycle pulse, if_data valid
if_data  out  32  fetched word
dm_req  in  1  data request; level, held until dm_done
dm_rw  in  1  1 = write, 0 = read
dm_size  in  2  00 byte, 01 half, 10 word, 11 treated as word
dm_addr  in  ADDR_WIDTH  data byte address
dm_wdata  in  32  write data; byte i = dm_wdata[8i+7:8i]
dm_done  out  1  one-cycle pulse, dm_rdata valid / write complete
dm_rdata  out  32  read data, zero-extended
mem_rw  out  1  memory write enable
mem_addr  out  ADDR_WIDTH  memory byte address
mem_write  out  8  memory write byte
mem_read  in  8  memory read byte; combinational from mem_addr
busy  out  1  high in XFER and DONE

Behaviour:
- Reset: state IDLE. All outputs 0: if_done, dm_done, if_data, dm_rdata, mem_rw, mem_addr, mem_write, busy. Count, latched address and latched data are cleared.
- States are IDLE, XFER and DONE.
- IDLE:
  - At a posedge with dm_req=1, latch the dm request: address, rw, byte count n (1/2/4) and wdata.
  - Otherwise, at a posedge with if_req=1, latch the if request with n=4 and read.
  - Data port wins on a tie. Go to XFER with cnt=0.
- XFER:
  - mem_addr = base+cnt, modulo 2^ADDR_WIDTH (wraps).
  - mem_rw = latched rw.
  - mem_write = byte cnt of latched wdata.
  - Read: at each posedge, capture mem_read into result[8cnt+7:8cnt].
  - At the posedge with cnt=n-1, go to DONE. Otherwise cnt increments.
- DONE, exactly one cycle:
  - The owner's done output is 1 and its data output holds the result. Upper bytes beyond n are 0.
  - For a write, dm_rdata is 0.
  - Requests are ignored in this cycle. Next state is IDLE.
- Outside XFER, mem_rw, mem_addr and mem_write are 0. Memory is never written outside XFER.
- Latency: request sampled at posedge E0 → done high in the cycle after posedge E0+n. A word access therefore takes 5 cycles from its accept edge; back-to-back accepts are 6 cycles apart.
- A request still high in the IDLE cycle after its done is accepted again. Requesters must drop req on seeing done.
- if_data and dm_rdata hold their value until the next done on the same port.
- Request inputs changing during XFER have no effect, because all fields are latched.
- Reset mid-XFER: abort at that edge and go to IDLE with outputs 0. Bytes already written stay written and no done is produced.

Decomposition:
- Package mem_arbiter_pkg holds:
  - size codes SZ_BYTE/SZ_HALF/SZ_WORD;
  - the state encoding;
  - an owner enum OWN_IF/OWN_DM;
  - a function size_to_count.
- One natural sub-module: mem_byte_assembler. It takes cnt, mem_read and a capture enable, and produces the result register with zero-fill.

Test Plan:
1. Memory [0..3]=83 20 40 06; if_req with if_addr=0 → mem_addr 0,1,2,3; mem_rw stays 0; if_done 5 cycles after the accept edge; if_data=0x06402083.
2. dm write, size=00, addr=100, wdata=0x123456AB → exactly one cycle with mem_rw=1, mem_addr=100, mem_write=0xAB; mem[101] unchanged; dm_done 2 cycles after accept.
3. Memory [100..103]=66 DB FF 55; dm read word at 100 and if_req at 0 raised on the same edge → dm served first, dm_rdata=0x55FFDB66. The IF request is then accepted in the IDLE cycle after dm_done; if_done 6 cycles after dm_done with if_data=0x06402083.
4. dm read half at addr 0xFFFFFFFF → mem_addr sequence 0xFFFFFFFF then 0x00000000; dm_rdata[31:16]=0.
5. Word write at 200 of 0xDDCCBBAA, reset high in the cycle with cnt=2 → mem[200]=AA and mem[201]=BB; mem[202..203] unchanged; no dm_done; all outputs 0 next cycle. A following IF read completes normally.
6. dm_req held high through dm_done into the next IDLE cycle → a second identical transaction runs; during the DONE cycle busy=1 and no accept occurs.
